rf_bypass_sb: RTL
=================

# rf_bypass_sb

Parametrised register file with write-through bypass and a per-register busy scoreboard for the pipelined datapath. Storage is `NREGS = 2**SELW` registers of `WIDTH` bits, with two combinational read ports and one synchronous write port. A reserve port marks a destination register busy when an instruction issues, and the matching write-back clears it. Read ports report busy status so issue logic can stall, and a sticky `err` flags double reservation.

## Interface
- `WIDTH`, default 16: data width of each register.
- `SELW`, default 3: select width; `NREGS = 2**SELW`.
- `ZERO_R0`, default 0: when 1, register 0 reads constant 0 and ignores writes and reserves.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset; synchronous and active-low.
- `read1regsel` input SELW: read port 1 select.
- `read2regsel` input SELW: read port 2 select.
- `writeregsel` input SELW: write select.
- `writedata` input WIDTH: write data.
- `write` input 1: write enable.
- `reserve` input 1: reserve enable; marks `reservesel` busy.
- `reservesel` input SELW: register to reserve.
- `read1data` output WIDTH: port 1 data.
- `read2data` output WIDTH: port 2 data.
- `read1busy` output 1: port 1 register awaiting write-back.
- `read2busy` output 1: port 2 register awaiting write-back.
- `err` output 1: sticky double-reservation flag.

## Operation
- **State:**
  - `regs[NREGS]`, each WIDTH bits.
  - `busy[NREGS]`, 1 bit each.
  - `err`, 1 bit.
- **Reset:** at a rising edge with `rst == 0`, all regs and busy bits go to 0 and `err` goes to 0. Write and reserve are ignored in that cycle. After the reset edge, `read*data = 0`, `read*busy = 0` and `err = 0`.
- **Write:** when `write == 1` (and `rst == 1`), then `regs[writeregsel] <= writedata` and `busy[writeregsel] <= 0`.
- **Reserve:** when `reserve == 1`, then `busy[reservesel] <= 1`.
- **Write and reserve on the same register in the same cycle:** data is written and busy ends at 1 (back-to-back producer; reserve wins).
- **Read port N (combinational):**
  - Bypass hit: `write == 1` and `writeregsel == readNregsel`. Then `readNdata = writedata` and `readNbusy = 0`.
  - Otherwise, `readNdata = regs[readNregsel]` and `readNbusy = busy[readNregsel]`.
  - Both ports may select the same register, and both get identical results.
- **ZERO_R0 = 1:**
  - Select 0 always reads data 0 with busy 0, including when a write to select 0 is present (no bypass).
  - Writes and reserves to select 0 are no-ops.
  - A reserve to select 0 never sets `err`.
- **Err:** `err <= 1` when `reserve == 1`, `busy[reservesel] == 1`, and there is no same-cycle write to `reservesel`. Once set, `err` stays 1 until reset. Data and busy updates proceed normally when `err` is set.
- **During `rst == 0`:** read ports show current storage with no bypass. Storage is cleared at the edge.

## Timing
- Read data and busy are combinational from selects, storage, and the write port; there are zero cycles of latency.
- A write is visible through bypass in the same cycle and from storage from the next cycle.
- A busy bit set by reserve is visible from the cycle after the reserve edge. The reserve never affects busy in its own cycle.
- `err` is registered: it asserts in the cycle after the offending reserve.
- There is no handshake; the issue logic must honour `read*busy` itself.
- Reset takes effect at the first rising edge with `rst` low. Any reservation in flight is discarded. A later write-back to a register that is not busy is legal and sets no error.

## Test plan
- **Reset:** drive random writes, then hold `rst = 0` for 1 edge. Required: all 8 registers read `0x0000`, both busy outputs 0, `err = 0`.
- **Write and read:** write `0x1234` to r3 and `0xBEEF` to r5 on consecutive cycles; then set `read1regsel = 3` and `read2regsel = 5`. Required: `read1data = 0x1234`, `read2data = 0xBEEF`. Set both selects to 5. Required: both ports read `0xBEEF`.
- **Bypass:** r2 holds `0x0001`; in one cycle set `write = 1`, `writeregsel = 2`, `writedata = 0xA5A5`, `read1regsel = 2`. Required: `read1data = 0xA5A5` that cycle and on every later cycle.
- **Scoreboard:**
  - Reserve r4 at edge k. Required: `read1busy = 1` for r4 from cycle k+1.
  - Write r4 `0x00FF` at edge k+3. Required: during cycle k+3, `read1busy = 0` and `read1data = 0x00FF` via bypass; after the edge, `busy[4] = 0`.
  - Reserve and write r6 in the same cycle. Required: r6 busy afterwards, with the new data stored.
- **Error:**
  - Reserve r1 twice with no intervening write. Required: `err = 1` the cycle after the second reserve, and it stays 1 through later writes.
  - Reserve r1 again in the same cycle as a write to r1. Required: no error (check this after a fresh reset).
  - Pulse reset. Required: `err = 0`.
- **ZERO_R0 = 1, WIDTH = 32, SELW = 4:**
  - Write `0xFFFFFFFF` to r0 and reserve r0. Required: r0 reads 0 with busy 0 and `err = 0`, including during the write cycle.
  - Write r15. Required: r15 reads back the value written (full width, top index).

Source files
------------

// File: rtl/rf_bypass_sb_if.sv
// Issue/write-back bus for rf_bypass_sb: read selects, write port, reserve port
// and the combinational read results plus the sticky error flag.
interface rf_bypass_sb_if #(
  parameter int WIDTH = 16,
  parameter int SELW  = 3
);
  logic [SELW-1:0]  read1regsel;
  logic [SELW-1:0]  read2regsel;
  logic [SELW-1:0]  writeregsel;
  logic [WIDTH-1:0] writedata;
  logic             write;
  logic             reserve;
  logic [SELW-1:0]  reservesel;
  logic [WIDTH-1:0] read1data;
  logic [WIDTH-1:0] read2data;
  logic             read1busy;
  logic             read2busy;
  logic             err;

  modport master (
    output read1regsel, read2regsel, writeregsel, writedata, write, reserve, reservesel,
    input  read1data, read2data, read1busy, read2busy, err
  );

  modport slave (
    input  read1regsel, read2regsel, writeregsel, writedata, write, reserve, reservesel,
    output read1data, read2data, read1busy, read2busy, err
  );
endinterface

// File: rtl/rf_bypass_sb.sv
// Register file with write-through bypass and a per-register busy scoreboard;
// err is a sticky flag raised when an already-busy register is reserved again.
module rf_bypass_sb #(
  parameter int WIDTH   = 16,
  parameter int SELW    = 3,
  parameter bit ZERO_R0 = 1'b0
) (
  input logic           clk,
  input logic           rst,
  rf_bypass_sb_if.slave bus
);
  localparam int NREGS = 2 ** SELW;

  logic [WIDTH-1:0] regs_r [NREGS];
  logic [NREGS-1:0] busy_r;
  logic             err_r;

  logic             wr_en_s;
  logic             rsv_en_s;
  logic             err_set_s;
  logic [WIDTH-1:0] rd1_data_s;
  logic [WIDTH-1:0] rd2_data_s;
  logic             rd1_busy_s;
  logic             rd2_busy_s;

  // With ZERO_R0, r0 is never written or reserved, so its storage stays zero and
  // disabling the write enable alone also suppresses the bypass for select 0.
  always_comb begin
    wr_en_s   = bus.write   && !(ZERO_R0 && (bus.writeregsel == {SELW{1'b0}}));
    rsv_en_s  = bus.reserve && !(ZERO_R0 && (bus.reservesel  == {SELW{1'b0}}));
    err_set_s = rsv_en_s && busy_r[bus.reservesel]
                && !(wr_en_s && (bus.writeregsel == bus.reservesel));
  end

  // Read port 1: bypass only while out of reset
  always_comb begin
    rd1_data_s = regs_r[bus.read1regsel];
    rd1_busy_s = busy_r[bus.read1regsel];
    if (rst && wr_en_s && (bus.writeregsel == bus.read1regsel)) begin
      rd1_data_s = bus.writedata;
      rd1_busy_s = 1'b0;
    end else begin
      rd1_data_s = regs_r[bus.read1regsel];
      rd1_busy_s = busy_r[bus.read1regsel];
    end
  end

  // Read port 2: same rule as port 1
  always_comb begin
    rd2_data_s = regs_r[bus.read2regsel];
    rd2_busy_s = busy_r[bus.read2regsel];
    if (rst && wr_en_s && (bus.writeregsel == bus.read2regsel)) begin
      rd2_data_s = bus.writedata;
      rd2_busy_s = 1'b0;
    end else begin
      rd2_data_s = regs_r[bus.read2regsel];
      rd2_busy_s = busy_r[bus.read2regsel];
    end
  end

  // Storage, scoreboard and sticky error; reserve after write so reserve wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
      busy_r <= {NREGS{1'b0}};
      err_r  <= 1'b0;
    end else begin
      if (wr_en_s) begin
        regs_r[bus.writeregsel] <= bus.writedata;
        busy_r[bus.writeregsel] <= 1'b0;
      end
      if (rsv_en_s) begin
        busy_r[bus.reservesel] <= 1'b1;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  assign bus.read1data = rd1_data_s;
  assign bus.read2data = rd2_data_s;
  assign bus.read1busy = rd1_busy_s;
  assign bus.read2busy = rd2_busy_s;
  assign bus.err       = err_r;
endmodule
